gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 143 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives the four input vectors of a 2-input gate under
// test, holds each for SETTLE_CYCLES, samples dut_y against the expected
// GATE_OP function and reports pass / per-vector mismatch flags at the end.
//
// Optional feature: define GATE_CHECK_ERRCNT_EN to add err_count, a
// saturating count of mismatching samples that persists across runs.
//
// Handshake: start is a level request sampled only in IDLE; a run is
// accepted on the rising edge where state is IDLE and start is 1. While
// busy=1 or during the DONE cycle start is ignored. done is a single-cycle
// pulse, and pass/fail_vec are valid from that pulse until the next
// accepted start.
module gate_truth_checker #(
    parameter int GATE_OP       = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_y,
    output logic       stim_a,
    output logic       stim_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
`ifdef GATE_CHECK_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter counts down to zero, so the sample edge is SETTLE_CYCLES
    // edges after the vector was applied.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic       exp_y;
    logic       sample;
    logic       last_vec;
    logic       mismatch;
    logic [3:0] fail_vec_nxt;

    // Expected gate output for the vector currently being applied.
    always_comb begin
        exp_y = 1'b0;
        case (GATE_OP)
            0:       exp_y = vec_q[1] & vec_q[0];
            1:       exp_y = vec_q[1] | vec_q[0];
            2:       exp_y = vec_q[1] ^ vec_q[0];
            default: exp_y = ~(vec_q[1] & vec_q[0]);
        endcase
    end

    assign sample       = (state_q == SETTLE) && (cnt_q == 4'd0);
    assign last_vec     = (vec_q == 2'd3);
    assign mismatch     = sample && (dut_y != exp_y);
    assign fail_vec_nxt = fail_vec | (mismatch ? (4'd1 << vec_q) : 4'd0);

    // Stimulus is forced to zero outside SETTLE, including during reset.
    assign stim_a    = (state_q == SETTLE) & vec_q[1];
    assign stim_b    = (state_q == SETTLE) & vec_q[0];
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: one run walks all four vectors, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (sample && last_vec) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run datapath: vector index, settle counter, result flags and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= 2'd0;
            cnt_q    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_vec <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q    <= 2'd0;
                        cnt_q    <= CNT_LOAD;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        fail_vec <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        fail_vec <= fail_vec_nxt;
                        if (last_vec) begin
                            vec_q <= 2'd0;
                            cnt_q <= 4'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_vec_nxt == 4'd0);
                        end else begin
                            vec_q <= vec_q + 2'd1;
                            cnt_q <= CNT_LOAD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GATE_CHECK_ERRCNT_EN
    // Lifetime mismatch counter; saturates and is cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            err_count <= 8'd0;
        else if (mismatch && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (AND/SETTLE=2 and XOR/SETTLE=1)
// driven by a behavioural gate model whose function can be swapped to inject
// faulty gates. Drivers push {pass, fail_vec, latency} into a queue per
// instance; monitors pop and compare on every done pulse.
module tb_gate_truth_checker;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       dut_y0, dut_y1;
    logic       stim_a0, stim_b0, stim_a1, stim_b1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] fv0, fv1;
    logic [1:0] dbg0, dbg1;
    logic [1:0] mode0, mode1;
`ifdef GATE_CHECK_ERRCNT_EN
    logic [7:0] err0, err1;
    int         exp_err0, exp_err1;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [12:0] exp_q0[$];
    logic [12:0] exp_q1[$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate model: 0=AND 1=OR 2=XOR 3=stuck-at-1.
    function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return 1'b1;
        endcase
    endfunction

    assign dut_y0 = gate_fn(mode0, stim_a0, stim_b0);
    assign dut_y1 = gate_fn(mode1, stim_a1, stim_b1);

    gate_truth_checker #(.GATE_OP(0), .SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(dut_y0),
        .stim_a(stim_a0), .stim_b(stim_b0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_vec(fv0),
`ifdef GATE_CHECK_ERRCNT_EN
        .err_count(err0),
`endif
        .state_dbg(dbg0)
    );

    gate_truth_checker #(.GATE_OP(2), .SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(dut_y1),
        .stim_a(stim_a1), .stim_b(stim_b1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_vec(fv1),
`ifdef GATE_CHECK_ERRCNT_EN
        .err_count(err1),
`endif
        .state_dbg(dbg1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor for u0: stimulus sequence every cycle, results on done.
    initial begin : mon0
        logic        busy_q = 1'b0;
        int          t0 = 0;
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy0 && !busy_q) t0 = cyc;
                if (busy0) chk("stim0_seq", {30'd0, stim_a0, stim_b0}, 32'((cyc - t0) / S0));
                else       chk("stim0_idle", {30'd0, stim_a0, stim_b0}, 32'd0);
                if (done0) begin
                    chk("done0_expected", 32'(exp_q0.size() != 0), 32'd1);
                    if (exp_q0.size() != 0) begin
                        e = exp_q0.pop_front();
                        chk("pass0", {31'd0, pass0}, {31'd0, e[12]});
                        chk("fail_vec0", {28'd0, fv0}, {28'd0, e[11:8]});
                        chk("latency0", 32'(cyc - t0), {24'd0, e[7:0]});
                        chk("busy0_at_done", {31'd0, busy0}, 32'd0);
                        chk("state0_at_done", {30'd0, dbg0}, 32'd2);
`ifdef GATE_CHECK_ERRCNT_EN
                        exp_err0 = exp_err0 + $countones(e[11:8]);
                        if (exp_err0 > 255) exp_err0 = 255;
                        chk("err_count0", {24'd0, err0}, 32'(exp_err0));
`endif
                    end
                end
            end
            busy_q = busy0;
        end
    end

    // Monitor for u1.
    initial begin : mon1
        logic        busy_q = 1'b0;
        int          t0 = 0;
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy1 && !busy_q) t0 = cyc;
                if (busy1) chk("stim1_seq", {30'd0, stim_a1, stim_b1}, 32'((cyc - t0) / S1));
                else       chk("stim1_idle", {30'd0, stim_a1, stim_b1}, 32'd0);
                if (done1) begin
                    chk("done1_expected", 32'(exp_q1.size() != 0), 32'd1);
                    if (exp_q1.size() != 0) begin
                        e = exp_q1.pop_front();
                        chk("pass1", {31'd0, pass1}, {31'd0, e[12]});
                        chk("fail_vec1", {28'd0, fv1}, {28'd0, e[11:8]});
                        chk("latency1", 32'(cyc - t0), {24'd0, e[7:0]});
`ifdef GATE_CHECK_ERRCNT_EN
                        exp_err1 = exp_err1 + $countones(e[11:8]);
                        if (exp_err1 > 255) exp_err1 = 255;
                        chk("err_count1", {24'd0, err1}, 32'(exp_err1));
`endif
                    end
                end
            end
            busy_q = busy1;
        end
    end

    // Driver tasks.
    task automatic wait_done0();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done0;
        end
        chk("done0_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_done1();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done1;
        end
        chk("done1_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run0(input logic [1:0] m, input logic ep, input logic [3:0] ef);
        @(negedge clk);
        mode0 = m;
        start0 = 1'b1;
        exp_q0.push_back({ep, ef, 8'(4 * S0)});
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();
    endtask

    task automatic run1(input logic [1:0] m, input logic ep, input logic [3:0] ef);
        @(negedge clk);
        mode1 = m;
        start1 = 1'b1;
        exp_q1.push_back({ep, ef, 8'(4 * S1)});
        @(negedge clk);
        start1 = 1'b0;
        wait_done1();
    endtask

    // Called at the done negedge: start held across the DONE cycle (ignored)
    // and accepted the following cycle from IDLE.
    task automatic chain0(input logic [1:0] m, input logic ep, input logic [3:0] ef);
        mode0 = m;
        start0 = 1'b1;
        exp_q0.push_back({ep, ef, 8'(4 * S0)});
        @(negedge clk);
        chk("chain0_ignored_in_done", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        start0 = 1'b0;
        chk("chain0_accepted", {31'd0, busy0}, 32'd1);
        chk("chain0_pass_cleared", {31'd0, pass0}, 32'd0);
        chk("chain0_fv_cleared", {28'd0, fv0}, 32'd0);
        wait_done0();
    endtask

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0 = 2'd0;
        mode1 = 2'd2;
`ifdef GATE_CHECK_ERRCNT_EN
        exp_err0 = 0;
        exp_err1 = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out0", {23'd0, stim_a0, stim_b0, busy0, done0, pass0, fv0}, 32'd0);
        chk("rst_state0", {30'd0, dbg0}, 32'd0);
        chk("rst_out1", {23'd0, stim_a1, stim_b1, busy1, done1, pass1, fv1}, 32'd0);
`ifdef GATE_CHECK_ERRCNT_EN
        chk("rst_err", {16'd0, err0, err1}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Correct AND gate, then OR gate substituted (vectors 01, 10 wrong).
        run0(2'd0, 1'b1, 4'b0000);
        run0(2'd1, 1'b0, 4'b0110);

        // Start re-asserted mid-run must not produce a second run.
        @(negedge clk);
        mode0 = 2'd0;
        start0 = 1'b1;
        exp_q0.push_back({1'b1, 4'b0000, 8'(4 * S0)});
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0();

        // Back-to-back runs: results cleared at each accept.
        chain0(2'd1, 1'b0, 4'b0110);
        chain0(2'd0, 1'b1, 4'b0000);
        run0(2'd3, 1'b0, 4'b0111);

        // XOR instance with SETTLE_CYCLES=1, then stuck-at-1 (00 and 11 wrong).
        run1(2'd2, 1'b1, 4'b0000);
        for (int r = 0; r < 130; r++) run1(2'd3, 1'b0, 4'b1001);
`ifdef GATE_CHECK_ERRCNT_EN
        chk("err1_saturated", {24'd0, err1}, 32'd255);
`endif

        // Reset in the middle of a run: outputs clear immediately, no done.
        @(negedge clk);
        mode0 = 2'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out0", {23'd0, stim_a0, stim_b0, busy0, done0, pass0, fv0}, 32'd0);
        chk("midrst_state0", {30'd0, dbg0}, 32'd0);
`ifdef GATE_CHECK_ERRCNT_EN
        chk("midrst_err", {16'd0, err0, err1}, 32'd0);
        exp_err0 = 0;
        exp_err1 = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {30'd0, done0, busy0}, 32'd0);
        end
        run0(2'd0, 1'b1, 4'b0000);
        run0(2'd1, 1'b0, 4'b0110);

        repeat (5) @(negedge clk);
        chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
        chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
